wb_stage_reg: RTL and testbench
===============================

Name: wb_stage_reg

Overview:
- Parametrised writeback stage for the pipelined RV32I core: the MEM/WB pipeline register plus the writeback result mux.
- Adds four result sources including LUI immediate, load byte/halfword extraction with sign/zero extension, and stall/flush control.
- Adds hold-capture of synchronous data-memory read data while stalled, x0 write suppression and a retired-instruction counter.
- Sits between the MEM stage and the register file; its result also feeds the forwarding unit.

Parameters:
- N, 32, datapath width (XLEN); must be 32 for load extraction.
- RA_W, 5, register-address width.
- CNT_W, 64, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_i  in  1  hold WB contents.
- flush_i  in  1  invalidate the incoming WB entry.
- m_valid_i  in  1  MEM-stage instruction valid.
- m_reg_write_i  in  1  instruction writes rd.
- m_rd_i  in  RA_W  destination register.
- m_result_src_i  in  2  result select: 00 ALU, 01 load, 10 pc+4, 11 immediate.
- m_funct3_i  in  3  load type.
- m_alu_result_i  in  N  ALU result; also the load address.
- m_pc_plus4_i  in  N  pc+4.
- m_imm_i  in  N  U-type immediate.
- rd_dm_i  in  N  synchronous DMEM read word, valid in the WB cycle.
- wb_valid_o  out  1  WB entry valid.
- wb_reg_write_o  out  1  register-file write enable.
- wb_rd_o  out  RA_W  register-file write address.
- wb_result_o  out  N  register-file write data.
- retire_cnt_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n low, asynchronous):
  - valid_q, all captured fields, hold flag and retire_cnt_o clear to 0.
  - Outputs read valid=0, reg_write=0, rd=0, result=0 (src field resets to 00 and the ALU field is 0).
  - Reset mid-stall discards the held instruction and held data.
- Pipeline register, per rising edge, in priority order:
  - flush_i: valid_q<=0, other fields don't-care. Flush overrides stall.
  - else stall_i: all fields hold.
  - else: capture all m_* inputs; valid_q<=m_valid_i.
- Outputs, combinational from registered state (latency 1 cycle from MEM inputs):
  - wb_reg_write_o = valid_q & reg_write_q & (rd_q != 0).
  - wb_rd_o = rd_q.
- Result mux:
  - 00 alu_q; 01 extracted load; 10 pc4_q; 11 imm_q.
  - The old 2-input behaviour where 11 fell back to load data is removed.
- Load extraction, with offset = alu_q[1:0] and the word source described under "Load data hold":
  - funct3 000 LB: byte at offset, sign-extended.
  - 001 LH: halfword at alu_q[1] (alu_q[0] ignored), sign-extended.
  - 010 LW: full word.
  - 100 LBU / 101 LHU: as LB/LH, zero-extended.
  - 011/110/111: full word, no trap.
- Load data hold:
  - hold_q sets on the first stall_i cycle while valid_q and the source is load, capturing rd_dm_i into held_q.
  - While hold_q is set, extraction uses held_q, otherwise rd_dm_i.
  - hold_q clears on advance (stall_i low) or flush.
- Retire counter: increments by 1 on each edge where valid_q & !stall_i & !flush_i; wraps to 0 at 2^CNT_W.
- Flush and stall together: entry invalidated, no retire, hold cleared.

Decomposition:
- Package rv_wb_pkg:
  - result_src enum: RES_ALU, RES_LOAD, RES_PC4, RES_IMM.
  - Load funct3 constants: F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
- One combinational sub-module, load_extend (funct3, offset, word -> extended result); the mux and registers stay in wb_stage_reg.

Test Plan:
- LB: m_alu_result_i=0x1003, src=01, f3=000, rd_dm_i=0x80FF1234 next cycle -> wb_result_o=0xFFFFFF80. Same case with LBU -> 0x00000080.
- LHU: addr=0x2002, rd_dm_i=0xBEEF0000 -> 0x0000BEEF. LH at the same address -> 0xFFFFBEEF.
- x0 suppression: rd=0, reg_write=1, src=00, alu=0x5 -> wb_reg_write_o=0, wb_result_o=0x5. With rd=3 -> wb_reg_write_o=1.
- Stall with load:
  - LW enters WB with rd_dm_i=0xCAFEF00D; stall_i held 3 cycles while rd_dm_i changes to 0x0.
  - Expected: wb_result_o stays 0xCAFEF00D, retire_cnt_o unchanged until release, then +1.
- Simultaneous flush+stall on a valid entry -> next cycle wb_valid_o=0, wb_reg_write_o=0, no retire increment.
- CNT_W=4 with 17 valid unstalled instructions -> counter reads 1 after wrap.
- Assert rst_n low mid-stall -> all outputs 0 immediately, asynchronously.
- src=11 with imm=0xABCDE000 -> wb_result_o=0xABCDE000.

Source files
------------

// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the RV32I writeback stage.
package rv_wb_pkg;

    // Writeback result source select, encoded as carried down the pipe.
    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_src_e;

    // Load funct3 encodings; the remaining codes read back the full word.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_reg_load_extend.sv
// Load data extraction: picks the byte/halfword addressed by the low
// address bits out of a memory word and sign- or zero-extends it.
module load_extend
    import rv_wb_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [2:0]   funct3_i,
    input  logic [1:0]   offset_i,
    input  logic [N-1:0] word_i,
    output logic [N-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, then extension by load type; unknown types return the word.
    always_comb begin
        byte_sel = word_i[{offset_i, 3'b000} +: 8];
        // Halfword lane comes from address bit 1 only; bit 0 is ignored.
        half_sel = word_i[{offset_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_LB:   result_o = {{(N-8){byte_sel[7]}}, byte_sel};
            F3_LH:   result_o = {{(N-16){half_sel[15]}}, half_sel};
            F3_LW:   result_o = word_i;
            F3_LBU:  result_o = {{(N-8){1'b0}}, byte_sel};
            F3_LHU:  result_o = {{(N-16){1'b0}}, half_sel};
            default: result_o = word_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register and writeback result mux for the RV32I core.
// Also captures synchronous DMEM read data while a load is stalled in WB
// and counts retired instructions.
module wb_stage_reg
    import rv_wb_pkg::*;
#(
    parameter int N     = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             m_valid_i,
    input  logic             m_reg_write_i,
    input  logic [RA_W-1:0]  m_rd_i,
    input  logic [1:0]       m_result_src_i,
    input  logic [2:0]       m_funct3_i,
    input  logic [N-1:0]     m_alu_result_i,
    input  logic [N-1:0]     m_pc_plus4_i,
    input  logic [N-1:0]     m_imm_i,
    input  logic [N-1:0]     rd_dm_i,
    output logic             wb_valid_o,
    output logic             wb_reg_write_o,
    output logic [RA_W-1:0]  wb_rd_o,
    output logic [N-1:0]     wb_result_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    logic              valid_q, valid_d;
    logic              reg_write_q, reg_write_d;
    logic [RA_W-1:0]   rd_q, rd_d;
    result_src_e       src_q, src_d;
    logic [2:0]        f3_q, f3_d;
    logic [N-1:0]      alu_q, alu_d;
    logic [N-1:0]      pc4_q, pc4_d;
    logic [N-1:0]      imm_q, imm_d;
    logic              hold_q, hold_d;
    logic [N-1:0]      held_q, held_d;
    logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

    logic [N-1:0]      load_word;
    logic [N-1:0]      load_res;

    // Next-state: flush beats stall beats advance. The load hold latches the
    // DMEM word on the first stalled cycle, since the memory only presents it
    // for one cycle after the address.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        rd_d         = rd_q;
        src_d        = src_q;
        f3_d         = f3_q;
        alu_d        = alu_q;
        pc4_d        = pc4_q;
        imm_d        = imm_q;
        hold_d       = hold_q;
        held_d       = held_q;
        retire_cnt_d = retire_cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
            hold_d  = 1'b0;
        end else if (stall_i) begin
            if (valid_q && (src_q == RES_LOAD) && !hold_q) begin
                hold_d = 1'b1;
                held_d = rd_dm_i;
            end
        end else begin
            valid_d     = m_valid_i;
            reg_write_d = m_reg_write_i;
            rd_d        = m_rd_i;
            src_d       = result_src_e'(m_result_src_i);
            f3_d        = m_funct3_i;
            alu_d       = m_alu_result_i;
            pc4_d       = m_pc_plus4_i;
            imm_d       = m_imm_i;
            hold_d      = 1'b0;
            if (valid_q) begin
                retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // State registers; reset also drops any held load data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            src_q        <= RES_ALU;
            f3_q         <= '0;
            alu_q        <= '0;
            pc4_q        <= '0;
            imm_q        <= '0;
            hold_q       <= 1'b0;
            held_q       <= '0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            rd_q         <= rd_d;
            src_q        <= src_d;
            f3_q         <= f3_d;
            alu_q        <= alu_d;
            pc4_q        <= pc4_d;
            imm_q        <= imm_d;
            hold_q       <= hold_d;
            held_q       <= held_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign load_word = hold_q ? held_q : rd_dm_i;

    load_extend #(.N(N)) u_load_extend (
        .funct3_i (f3_q),
        .offset_i (alu_q[1:0]),
        .word_i   (load_word),
        .result_o (load_res)
    );

    // Writeback result select.
    always_comb begin
        case (src_q)
            RES_ALU:  wb_result_o = alu_q;
            RES_LOAD: wb_result_o = load_res;
            RES_PC4:  wb_result_o = pc4_q;
            RES_IMM:  wb_result_o = imm_q;
            default:  wb_result_o = alu_q;
        endcase
    end

    // Writes to x0 are dropped here so the regfile and forwarding never see them.
    assign wb_valid_o     = valid_q;
    assign wb_reg_write_o = valid_q & reg_write_q & (rd_q != '0);
    assign wb_rd_o        = rd_q;
    assign retire_cnt_o   = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Scoreboard bench for wb_stage_reg: expected WB entries are queued when the
// MEM-side stimulus is driven and popped once the entry sits in WB.
module tb_wb_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i;
    logic        m_valid_i, m_reg_write_i;
    logic [4:0]  m_rd_i;
    logic [1:0]  m_result_src_i;
    logic [2:0]  m_funct3_i;
    logic [31:0] m_alu_result_i, m_pc_plus4_i, m_imm_i, rd_dm_i;

    logic        wb_valid_o, wb_reg_write_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_result_o;
    logic [63:0] retire_cnt_o;

    logic        d4_valid, d4_reg_write;
    logic [4:0]  d4_rd;
    logic [31:0] d4_result;
    logic [3:0]  d4_cnt;

    typedef struct packed {
        logic        v;
        logic        w;
        logic [4:0]  rd;
        logic [31:0] res;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_cnt = 64'd0;

    always #5 clk = ~clk;

    wb_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .m_valid_i(m_valid_i), .m_reg_write_i(m_reg_write_i), .m_rd_i(m_rd_i),
        .m_result_src_i(m_result_src_i), .m_funct3_i(m_funct3_i),
        .m_alu_result_i(m_alu_result_i), .m_pc_plus4_i(m_pc_plus4_i),
        .m_imm_i(m_imm_i), .rd_dm_i(rd_dm_i),
        .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o),
        .wb_rd_o(wb_rd_o), .wb_result_o(wb_result_o), .retire_cnt_o(retire_cnt_o)
    );

    wb_stage_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .m_valid_i(m_valid_i), .m_reg_write_i(m_reg_write_i), .m_rd_i(m_rd_i),
        .m_result_src_i(m_result_src_i), .m_funct3_i(m_funct3_i),
        .m_alu_result_i(m_alu_result_i), .m_pc_plus4_i(m_pc_plus4_i),
        .m_imm_i(m_imm_i), .rd_dm_i(rd_dm_i),
        .wb_valid_o(d4_valid), .wb_reg_write_o(d4_reg_write),
        .wb_rd_o(d4_rd), .wb_result_o(d4_result), .retire_cnt_o(d4_cnt)
    );

    task automatic idle();
        m_valid_i = 1'b0; m_reg_write_i = 1'b0; m_rd_i = '0;
        m_result_src_i = 2'b00; m_funct3_i = 3'b000;
        m_alu_result_i = '0; m_pc_plus4_i = '0; m_imm_i = '0;
    endtask

    // Drive one MEM-stage instruction and queue what WB should show for it.
    task automatic send(input logic v, input logic wr, input logic [4:0] rd,
                        input logic [1:0] src, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [31:0] imm, input logic [31:0] res);
        exp_t x;
        m_valid_i = v; m_reg_write_i = wr; m_rd_i = rd; m_result_src_i = src;
        m_funct3_i = f3; m_alu_result_i = alu; m_pc_plus4_i = pc4; m_imm_i = imm;
        x.v = v; x.w = v & wr & (rd != 5'd0); x.rd = rd; x.res = res;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0; rd_dm_i = 32'h1234_5678;
        idle();
        #2;
        checks++;
        if ({wb_valid_o, wb_reg_write_o, wb_rd_o, wb_result_o} !== 39'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b w=%b rd=%0d res=%h exp all 0",
                     wb_valid_o, wb_reg_write_o, wb_rd_o, wb_result_o);
        end
        checks++;
        if (retire_cnt_o !== 64'd0 || d4_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_count got %0d/%0d exp 0", retire_cnt_o, d4_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_loads();
        logic [31:0] t_alu[12] = '{32'h1003, 32'h1003, 32'h2002, 32'h2002, 32'h1000, 32'h1001,
                                   32'h1002, 32'h1002, 32'h1000, 32'h1000, 32'h1000, 32'h2002};
        logic [2:0]  t_f3[12]  = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b001,
                                   3'b100, 3'b000, 3'b010, 3'b011, 3'b110, 3'b001};
        logic [31:0] t_dm[12]  = '{32'h80FF1234, 32'h80FF1234, 32'hBEEF0000, 32'hBEEF0000,
                                   32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234,
                                   32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h7FFF0000};
        logic [31:0] t_exp[12] = '{32'hFFFFFF80, 32'h00000080, 32'h0000BEEF, 32'hFFFFBEEF,
                                   32'h00000034, 32'h00001234, 32'h000000FF, 32'hFFFFFFFF,
                                   32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h00007FFF};
        for (int i = 0; i < 12; i++) begin
            send(1'b1, 1'b1, 5'd10, 2'b01, t_f3[i], t_alu[i], 32'h0, 32'h0, t_exp[i]);
            @(posedge clk); #1;
            idle();
            rd_dm_i = t_dm[i];
            #1;
            e = sb.pop_front();
            checks++;
            if (wb_result_o !== e.res || wb_reg_write_o !== e.w) begin
                errors++;
                $display("FAIL load[%0d] got res=%h w=%b exp res=%h w=%b",
                         i, wb_result_o, wb_reg_write_o, e.res, e.w);
            end
            exp_cnt++;
        end
        @(posedge clk); #1;
        checks++;
        if (retire_cnt_o !== exp_cnt) begin
            errors++;
            $display("FAIL load_retire got %0d exp %0d", retire_cnt_o, exp_cnt);
        end
    endtask

    task automatic test_x0();
        logic [4:0] t_rd[2] = '{5'd0, 5'd3};
        for (int i = 0; i < 2; i++) begin
            send(1'b1, 1'b1, t_rd[i], 2'b00, 3'b000, 32'h5, 32'h0, 32'h0, 32'h5);
            @(posedge clk); #1;
            idle();
            #1;
            e = sb.pop_front();
            checks++;
            if (wb_reg_write_o !== e.w || wb_result_o !== e.res || wb_rd_o !== e.rd) begin
                errors++;
                $display("FAIL x0[%0d] got w=%b rd=%0d res=%h exp w=%b rd=%0d res=%h",
                         i, wb_reg_write_o, wb_rd_o, wb_result_o, e.w, e.rd, e.res);
            end
            exp_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sources();
        send(1'b1, 1'b1, 5'd6, 2'b11, 3'b000, 32'h1111, 32'h2222, 32'hABCDE000, 32'hABCDE000);
        @(posedge clk); #1;
        idle(); rd_dm_i = 32'h5A5A5A5A;
        #1;
        e = sb.pop_front();
        checks++;
        if (wb_result_o !== e.res) begin
            errors++;
            $display("FAIL src_imm got %h exp %h", wb_result_o, e.res);
        end
        exp_cnt++;
        send(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'h1111, 32'h0000_0404, 32'hABCDE000, 32'h0000_0404);
        @(posedge clk); #1;
        idle();
        #1;
        e = sb.pop_front();
        checks++;
        if (wb_result_o !== e.res || wb_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL src_pc4 got %h v=%b exp %h v=1", wb_result_o, wb_valid_o, e.res);
        end
        exp_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_stall_load();
        send(1'b1, 1'b1, 5'd7, 2'b01, 3'b010, 32'h3000, 32'h0, 32'h0, 32'hCAFEF00D);
        @(posedge clk); #1;
        rd_dm_i = 32'hCAFEF00D;
        stall_i = 1'b1;
        // A younger instruction waits in MEM and must not be captured.
        m_valid_i = 1'b1; m_reg_write_i = 1'b1; m_rd_i = 5'd9; m_result_src_i = 2'b00;
        m_alu_result_i = 32'h99;
        #1;
        e = sb.pop_front();
        checks++;
        if (wb_result_o !== e.res || retire_cnt_o !== exp_cnt) begin
            errors++;
            $display("FAIL stall_first got res=%h cnt=%0d exp res=%h cnt=%0d",
                     wb_result_o, retire_cnt_o, e.res, exp_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            rd_dm_i = 32'h0;
            #1;
            checks++;
            if (wb_result_o !== e.res || wb_rd_o !== e.rd || wb_valid_o !== 1'b1 ||
                retire_cnt_o !== exp_cnt) begin
                errors++;
                $display("FAIL stall_hold[%0d] got res=%h rd=%0d v=%b cnt=%0d exp res=%h rd=%0d v=1 cnt=%0d",
                         k, wb_result_o, wb_rd_o, wb_valid_o, retire_cnt_o, e.res, e.rd, exp_cnt);
            end
        end
        @(posedge clk); #1;
        stall_i = 1'b0;
        idle();
        #1;
        checks++;
        if (wb_result_o !== e.res || retire_cnt_o !== exp_cnt) begin
            errors++;
            $display("FAIL stall_release got res=%h cnt=%0d exp res=%h cnt=%0d",
                     wb_result_o, retire_cnt_o, e.res, exp_cnt);
        end
        exp_cnt++;
        @(posedge clk); #1;
        checks++;
        if (retire_cnt_o !== exp_cnt || wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_retire got cnt=%0d v=%b exp cnt=%0d v=0",
                     retire_cnt_o, wb_valid_o, exp_cnt);
        end
    endtask

    task automatic test_flush_stall();
        send(1'b1, 1'b1, 5'd4, 2'b00, 3'b000, 32'h44, 32'h0, 32'h0, 32'h44);
        @(posedge clk); #1;
        idle();
        #1;
        e = sb.pop_front();
        checks++;
        if (wb_result_o !== e.res || wb_reg_write_o !== e.w) begin
            errors++;
            $display("FAIL flush_pre got res=%h w=%b exp res=%h w=%b",
                     wb_result_o, wb_reg_write_o, e.res, e.w);
        end
        stall_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        stall_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (wb_valid_o !== 1'b0 || wb_reg_write_o !== 1'b0 || retire_cnt_o !== exp_cnt) begin
            errors++;
            $display("FAIL flush_stall got v=%b w=%b cnt=%0d exp v=0 w=0 cnt=%0d",
                     wb_valid_o, wb_reg_write_o, retire_cnt_o, exp_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_stall();
        send(1'b1, 1'b1, 5'd8, 2'b01, 3'b010, 32'h4000, 32'h0, 32'h0, 32'h11223344);
        @(posedge clk); #1;
        idle();
        rd_dm_i = 32'h11223344;
        stall_i = 1'b1;
        #1;
        e = sb.pop_front();
        checks++;
        if (wb_result_o !== e.res) begin
            errors++;
            $display("FAIL rst_stall_pre got %h exp %h", wb_result_o, e.res);
        end
        @(posedge clk); #1;
        rd_dm_i = 32'h0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_valid_o, wb_reg_write_o, wb_rd_o, wb_result_o} !== 39'd0 ||
            retire_cnt_o !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_stall got v=%b w=%b rd=%0d res=%h cnt=%0d exp all 0",
                     wb_valid_o, wb_reg_write_o, wb_rd_o, wb_result_o, retire_cnt_o);
        end
        rst_n = 1'b1;
        stall_i = 1'b0;
        exp_cnt = 64'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 17; i++) begin
            send(1'b1, 1'b1, 5'(i % 31 + 1), 2'b00, 3'b000, 32'h100 + 32'(i), 32'h0, 32'h0,
                 32'h100 + 32'(i));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if (wb_result_o !== e.res || wb_rd_o !== e.rd || wb_reg_write_o !== e.w) begin
                errors++;
                $display("FAIL b2b[%0d] got res=%h rd=%0d w=%b exp res=%h rd=%0d w=%b",
                         i, wb_result_o, wb_rd_o, wb_reg_write_o, e.res, e.rd, e.w);
            end
            if (i == 16) begin
                checks++;
                if (d4_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL wrap_zero got %0d exp 0", d4_cnt);
                end
            end
            exp_cnt++;
        end
        idle();
        @(posedge clk); #1;
        checks++;
        if (retire_cnt_o !== exp_cnt) begin
            errors++;
            $display("FAIL b2b_retire got %0d exp %0d", retire_cnt_o, exp_cnt);
        end
        checks++;
        if (d4_cnt !== exp_cnt[3:0] || d4_cnt !== 4'd1) begin
            errors++;
            $display("FAIL wrap_cnt4 got %0d exp 1", d4_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_x0();
        test_sources();
        test_stall_load();
        test_flush_stall();
        test_reset_mid_stall();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
